// File: rtl/expr_result_if.sv
// Result-vector handshake between an expression block (master) and its capture stage (slave).
interface expr_result_if #(
  parameter int Y_W = 90
) ();
  logic           in_valid;
  logic           in_ready;
  logic [Y_W-1:0] in_y;

  modport master (output in_valid, output in_y, input in_ready);
  modport slave  (input in_valid, input in_y, output in_ready);
endinterface

// File: rtl/expr_result_compactor.sv
// Compacts 90-bit expression results into a 32-bit MISR signature, one vector per cycle.
// Optional per-field parity accumulator: define EXPR_COMPACT_FIELD_PARITY_EN.
module expr_result_compactor #(
  parameter int              Y_W   = 90,
  parameter int              SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY = 32'h04C1_1DB7,
  parameter int              CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_num_vectors,
  input  logic [SIG_W-1:0]  cfg_seed,
  expr_result_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  sig,
  output logic [CNT_W-1:0]  vec_count
`ifdef EXPR_COMPACT_FIELD_PARITY_EN
  ,
  output logic [17:0]       field_par
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] rem;
  logic             stage_valid;
  logic [Y_W-1:0]   stage_y;
  logic             load, accept;
  logic [SIG_W-1:0] fold, stepped;

  assign load   = start && (state == IDLE || state == DONE);
  assign accept = bus.in_valid && bus.in_ready;

  assign fold    = stage_y[31:0] ^ stage_y[63:32]
                 ^ {{(SIG_W-(Y_W-64)){1'b0}}, stage_y[Y_W-1:64]};
  assign stepped = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // RUN waits until rem hits zero, so the last vector is folded on the
  // RUN->DRAIN edge and done appears two edges after the final accept.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = (cfg_num_vectors == '0) ? DONE : RUN;
      RUN:        if (rem == '0) state_next = DRAIN;
      DRAIN:      state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == RUN) && (rem != '0);
    busy         = (state == RUN) || (state == DRAIN);
    done         = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig         <= '0;
      vec_count   <= '0;
      rem         <= '0;
      stage_valid <= 1'b0;
      stage_y     <= '0;
    end else if (load) begin
      sig         <= cfg_seed;
      vec_count   <= '0;
      rem         <= cfg_num_vectors;
      stage_valid <= 1'b0;
    end else begin
      if (stage_valid) begin
        sig       <= stepped ^ fold;
        vec_count <= vec_count + 1'b1;
      end
      stage_valid <= accept;
      if (accept) begin
        stage_y <= bus.in_y;
        rem     <= rem - 1'b1;
      end
    end
  end

`ifdef EXPR_COMPACT_FIELD_PARITY_EN
  logic [17:0] field_bits;

  // Fields are packed MSB-first in groups of 15 bits with widths 4,5,6.
  generate
    for (genvar gi = 0; gi < 18; gi++) begin : g_field
      localparam int W   = 4 + (gi % 3);
      localparam int OFF = (gi / 3) * 15 + ((gi % 3 == 0) ? 0 : ((gi % 3 == 1) ? 4 : 9));
      assign field_bits[17-gi] = ^stage_y[Y_W-1-OFF -: W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           field_par <= '0;
    else if (load)        field_par <= '0;
    else if (stage_valid) field_par <= field_par ^ field_bits;
  end
`endif

endmodule

// File: tb/tb_expr_result_compactor.sv
// Directed table-driven bench for expr_result_compactor plus hand-written multi-cycle sequences.
module tb_expr_result_compactor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_num_vectors = '0;
  logic [31:0] cfg_seed = '0;
  logic        busy, done;
  logic [31:0] sig;
  logic [15:0] vec_count;
`ifdef EXPR_COMPACT_FIELD_PARITY_EN
  logic [17:0] field_par;
`endif

  expr_result_if #(.Y_W(90)) bus ();

  expr_result_compactor dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .cfg_num_vectors (cfg_num_vectors),
    .cfg_seed        (cfg_seed),
    .bus             (bus),
    .busy            (busy),
    .done            (done),
    .sig             (sig),
    .vec_count       (vec_count)
`ifdef EXPR_COMPACT_FIELD_PARITY_EN
    ,
    .field_par       (field_par)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] seed;
    logic [89:0] y;
    logic [31:0] exp_sig;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] seed, input logic [15:0] n);
    cfg_seed        = seed;
    cfg_num_vectors = n;
    start           = 1'b1;
    tick();
    start           = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 90'h1,                              32'h0000_0001};
    vecs[1] = '{32'h0000_0000, (90'h1 << 64) | (90'h1 << 32) | 90'h1, 32'h0000_0001};
    vecs[2] = '{32'h8000_0000, (90'h1 << 64) | (90'h1 << 32) | 90'h1, 32'h04C1_1DB6};
    vecs[3] = '{32'h0000_0001, 90'h0,                              32'h0000_0002};
    vecs[4] = '{32'h1234_5678, 90'hFFFF_FFFF,                      32'hDB97_530F};
    vecs[5] = '{32'h0000_0000, {26'h3FF_FFFF, 64'h0},              32'h03FF_FFFF};
    vecs[6] = '{32'hFFFF_FFFF, 90'h0,                              32'hFB3E_E249};

    bus.in_valid = 1'b0;
    bus.in_y     = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Reset / idle state, and in_valid while idle is ignored
    check("reset_sig", sig, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_ready", {31'b0, bus.in_ready}, 32'h0);
    check("reset_count", {16'b0, vec_count}, 32'h0);
    bus.in_valid = 1'b1;
    bus.in_y     = 90'h1234;
    tick(); tick();
    check("idle_no_accept_sig", sig, 32'h0);
    check("idle_no_accept_cnt", {16'b0, vec_count}, 32'h0);
    bus.in_valid = 1'b0;

    // Single-vector runs from the table
    for (int i = 0; i < 7; i++) begin
      pulse_start(vecs[i].seed, 16'd1);
      check($sformatf("v%0d_ready", i), {31'b0, bus.in_ready}, 32'h1);
      bus.in_valid = 1'b1;
      bus.in_y     = vecs[i].y;
      tick();
      bus.in_valid = 1'b0;
      bus.in_y     = ~vecs[i].y;
      check($sformatf("v%0d_ready_low", i), {31'b0, bus.in_ready}, 32'h0);
      tick();
      check($sformatf("v%0d_sig", i), sig, vecs[i].exp_sig);
      check($sformatf("v%0d_count", i), {16'b0, vec_count}, 32'h1);
      check($sformatf("v%0d_done_early", i), {31'b0, done}, 32'h0);
      tick();
      check($sformatf("v%0d_done", i), {31'b0, done}, 32'h1);
      $display("vector %0d: seed=%h sig=%h count=%0d done=%0d", i, vecs[i].seed, sig, vec_count, done);
    end

    // Two back-to-back vectors, with a start pulse inside the run that must be ignored
    pulse_start(32'h0, 16'd2);
    bus.in_valid = 1'b1;
    bus.in_y     = 90'h1;
    tick();
    start = 1'b1; cfg_seed = 32'hDEAD_BEEF; cfg_num_vectors = 16'd7;
    bus.in_y = 90'h0;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b0;
    check("b2b_busy", {31'b0, busy}, 32'h1);
    tick(); tick();
    check("b2b_sig", sig, 32'h2);
    check("b2b_count", {16'b0, vec_count}, 32'h2);
    check("b2b_done", {31'b0, done}, 32'h1);
    $display("back-to-back: sig=%h count=%0d", sig, vec_count);

    // N=0: done one cycle after start, in_ready never high, sig=seed
    bus.in_valid = 1'b1;
    pulse_start(32'hCAFE_F00D, 16'd0);
    check("n0_done", {31'b0, done}, 32'h1);
    check("n0_ready", {31'b0, bus.in_ready}, 32'h0);
    check("n0_sig", sig, 32'hCAFE_F00D);
    check("n0_count", {16'b0, vec_count}, 32'h0);
    tick();
    check("n0_hold_sig", sig, 32'hCAFE_F00D);
    bus.in_valid = 1'b0;
    $display("n=0 run: sig=%h done=%0d", sig, done);

    // Reset mid-run after two accepts
    pulse_start(32'h5555_AAAA, 16'd5);
    bus.in_valid = 1'b1;
    bus.in_y     = 90'h3;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_sig", sig, 32'h0);
    check("rst_mid_count", {16'b0, vec_count}, 32'h0);
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_ready", {31'b0, bus.in_ready}, 32'h0);
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start(32'h0, 16'd1);
    bus.in_valid = 1'b1;
    bus.in_y     = 90'h1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    check("post_rst_sig", sig, 32'h1);
    check("post_rst_count", {16'b0, vec_count}, 32'h1);
    check("post_rst_done", {31'b0, done}, 32'h1);
`ifdef EXPR_COMPACT_FIELD_PARITY_EN
    check("post_rst_field_par", {14'b0, field_par}, 32'h1);
`endif
    $display("after reset: sig=%h count=%0d done=%0d", sig, vec_count, done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
